// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_B     = 8'h32;
  localparam logic [7:0] KEY_A     = 8'h1C;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length filter: the output level only
// follows the input after FILTER_LEN consecutive samples at the new level.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive synchronised samples that disagree with the filtered level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser and filter state; idle PS/2 lines float high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: presents each scan code on Key for one
// cycle with Valid, or pulses FrameError on parity/stop/timeout failures.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] Key,
  output logic       Valid,
  output logic       FrameError
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  logic clk_f, dat_f;
  logic clk_prev_q;
  logic fall;

  ps2_state_e     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [7:0]     key_q, key_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (Clock),
    .rst_n (Resetn),
    .din   (PS2_CLK),
    .dout  (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk   (Clock),
    .rst_n (Resetn),
    .din   (PS2_DAT),
    .dout  (dat_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  // Frame sequencing, parity accumulation, watchdog and output pulse generation.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    key_d     = KEY_NONE;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (fall || state_q == IDLE) begin
      wdog_d = '0;
    end else if (wdog_q != WDW'(TIMEOUT)) begin
      wdog_d = wdog_q + 1'b1;
    end else begin
      wdog_d = wdog_q;
    end

    case (state_q)
      IDLE: begin
        if (fall && !dat_f) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          parity_d  = 1'b0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {dat_f, shift_q[7:1]};
          parity_d  = parity_q ^ dat_f;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = parity_q ^ dat_f;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          // parity_q now holds XOR of data and parity bits; 1 means odd parity held.
          if (dat_f && parity_q) begin
            valid_d = 1'b1;
            key_d   = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall in the same cycle as expiry keeps the frame alive.
    if (!fall && state_q != IDLE && wdog_q == WDW'(TIMEOUT)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wdog_q     <= '0;
      key_q      <= KEY_NONE;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      wdog_q     <= wdog_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign Key        = key_q;
  assign Valid      = valid_q;
  assign FrameError = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised frame bench for ps2_scancode_rx with a frame-level reference model.
module tb_ps2_scancode_rx;

  localparam int unsigned HALF = 40;
  localparam int unsigned TO   = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] key;
  logic       valid;
  logic       ferr;

  always #10 clk = ~clk;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .PS2_CLK    (ps2_clk),
    .PS2_DAT    (ps2_dat),
    .Key        (key),
    .Valid      (valid),
    .FrameError (ferr)
  );

  typedef struct {
    logic [7:0]  key;
    logic        valid;
    logic        ferr;
    int unsigned cyc;
  } ev_t;

  ev_t         evq[$];
  ev_t         expq[$];
  int unsigned cyc = 0;
  int unsigned last_fall_cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which any output is active.
  always @(negedge clk) begin
    if (rst_n && (valid || ferr || key != 8'h00))
      evq.push_back('{key: key, valid: valid, ferr: ferr, cyc: cyc});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input bit b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      idle(10);
      ps2_dat = ~b;
      idle(3);
      ps2_dat = b;
      idle(HALF - 13);
    end else begin
      idle(HALF);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; parity/stop can be corrupted.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int unsigned nbits);
    bit [10:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    bits[9]  = (($countones(data) % 2) == 0) ^ bad_par;
    bits[10] = ~bad_stop;
    for (int i = 0; i < int'(nbits); i++) ps2_bit(bits[i], glitch && i > 0 && i < 9);
    ps2_dat = 1'b1;
    // Reference: good frame iff data+parity has odd ones and stop bit is 1.
    if (nbits == 11) begin
      if ((($countones(data) + int'(bits[9])) % 2 == 1) && bits[10])
        expq.push_back('{key: data, valid: 1'b1, ferr: 1'b0, cyc: 0});
      else
        expq.push_back('{key: 8'h00, valid: 1'b0, ferr: 1'b1, cyc: 0});
    end
  endtask

  task automatic check_events(input string tag);
    int unsigned prev;
    idle(60);
    check_eq({tag, "_count"}, evq.size(), expq.size());
    prev = 0;
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      check_eq({tag, "_key"},   {24'h0, evq[i].key}, {24'h0, expq[i].key});
      check_eq({tag, "_valid"}, {31'h0, evq[i].valid}, {31'h0, expq[i].valid});
      check_eq({tag, "_ferr"},  {31'h0, evq[i].ferr}, {31'h0, expq[i].ferr});
      if (i > 0) check_eq({tag, "_gap"}, {31'h0, evq[i].cyc > prev + 1}, 32'h1);
      prev = evq[i].cyc;
    end
    evq.delete();
    expq.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         bp, bs;
    int unsigned delta;

    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    idle(5);
    check_eq("rst_key",   {24'h0, key}, 32'h0);
    check_eq("rst_valid", {31'h0, valid}, 32'h0);
    check_eq("rst_ferr",  {31'h0, ferr}, 32'h0);
    rst_n = 1'b1;
    idle(20);

    // Good make code
    send_frame(ps2_pkg::KEY_UP, 1'b0, 1'b0, 1'b0, 11);
    check_events("up");

    // Inverted parity
    send_frame(ps2_pkg::KEY_A, 1'b1, 1'b0, 1'b0, 11);
    check_events("badpar");

    // Bad stop bit
    send_frame(ps2_pkg::KEY_B, 1'b0, 1'b1, 1'b0, 11);
    check_events("badstop");

    // Partial frame then watchdog expiry
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 6);
    idle(TO + 50);
    check_eq("to_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      check_eq("to_ferr",  {31'h0, evq[0].ferr}, 32'h1);
      check_eq("to_valid", {31'h0, evq[0].valid}, 32'h0);
      delta = evq[0].cyc - last_fall_cyc;
      check_eq("to_delay", {31'h0, (delta >= TO) && (delta <= TO + 30)}, 32'h1);
    end
    evq.delete();
    send_frame(ps2_pkg::KEY_ENTER, 1'b0, 1'b0, 1'b0, 11);
    check_events("enter");

    // Short clock glitch while idle, then data glitches mid-bit
    ps2_clk = 1'b0;
    idle(3);
    ps2_clk = 1'b1;
    idle(40);
    check_events("clkglitch");
    send_frame(ps2_pkg::KEY_DOWN, 1'b0, 1'b0, 1'b1, 11);
    check_events("down_glitch");

    // Back-to-back extended break sequence
    send_frame(ps2_pkg::KEY_EXT,   1'b0, 1'b0, 1'b0, 11);
    send_frame(ps2_pkg::KEY_BREAK, 1'b0, 1'b0, 1'b0, 11);
    send_frame(ps2_pkg::KEY_UP,    1'b0, 1'b0, 1'b0, 11);
    check_events("seq");

    // Reset mid-frame after 4 data bits
    send_frame(ps2_pkg::KEY_LEFT, 1'b0, 1'b0, 1'b0, 5);
    rst_n = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(TO + 50);
    check_events("abort");
    send_frame(ps2_pkg::KEY_RIGHT, 1'b0, 1'b0, 1'b0, 11);
    check_events("right");

    // Overrun code
    send_frame(ps2_pkg::KEY_NONE, 1'b0, 1'b0, 1'b0, 11);
    check_events("overrun");

    // Randomised frames
    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 6) == 0);
      send_frame(d, bp, bs, 1'b0, 11);
      check_events("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
